// File: rtl/qspi_arb.sv
// qspi_arb: shares the QSPI line engine between icache and dcache with
// round-robin fairness, writeback/refill locking and a transfer watchdog.
//
// state  | meaning
// IDLE   | engine free, arbitrating every cycle
// XFER_I | icache line fill in flight, command frozen
// XFER_D | dcache writeback or fill in flight, command frozen
module qspi_arb #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int TIMEOUT     = 255,
  localparam int TW         = PA - $clog2(LINE_LENGTH),
  localparam int CW         = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic          i_rom,
  input  logic          d_req,
  input  logic          d_push,
  input  logic [TW-1:0] d_tag,
  input  logic          d_rom,
  input  logic          q_done,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic          q_mem,
  output logic [TW-1:0] q_tag,
  output logic          i_gnt,
  output logic          d_gnt,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [1:0] {IDLE, XFER_I, XFER_D} state_t;

  // Watchdog counts down from TIMEOUT-1; terminal count at zero gives
  // exactly TIMEOUT cycles of q_req.
  localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          grant_i, grant_d;
  logic          wd_tc;
  logic          last_d;
  logic          lock;
  logic [CW-1:0] wd_cnt;

  assign grant_d = (state == IDLE) && d_req && (lock || !i_req || !last_d);
  assign grant_i = (state == IDLE) && i_req && !grant_d;
  assign wd_tc   = (wd_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = XFER_D;
        else if (grant_i) state_nxt = XFER_I;
      end
      XFER_I, XFER_D: begin
        if (q_done || wd_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_req = (state != IDLE);
    i_gnt = (state == XFER_I);
    d_gnt = (state == XFER_D);
    busy  = (state != IDLE);
  end

  // Command capture, round-robin history, lock and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_mem   <= 1'b0;
      q_tag   <= '0;
      timeout <= 1'b0;
      last_d  <= 1'b0;
      lock    <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      if (grant_d || grant_i) begin
        q_i_d   <= grant_i;
        q_write <= grant_d && d_push;
        q_mem   <= grant_d ? (d_rom && !d_push) : i_rom;
        q_tag   <= grant_d ? d_tag : i_tag;
        wd_cnt  <= WD_LOAD;
        last_d  <= grant_d;
        lock    <= 1'b0;
      end else if (state != IDLE) begin
        // q_done has priority over a coincident watchdog terminal count
        if (q_done) begin
          lock <= (state == XFER_D) && q_write;
        end else if (wd_tc) begin
          lock    <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// Scoreboard bench for qspi_arb: stimulus pushes expected transfers,
// a monitor checks each transfer as the DUT raises and drops q_req.
module tb_qspi_arb;
  localparam int PA = 22;
  localparam int LINE_LENGTH = 4;
  localparam int TIMEOUT = 255;
  localparam int TW = PA - $clog2(LINE_LENGTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_rom, d_req, d_push, d_rom, q_done;
  logic [TW-1:0] i_tag, d_tag;
  logic          q_req, q_i_d, q_write, q_mem, i_gnt, d_gnt, busy, timeout;
  logic [TW-1:0] q_tag;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_rom(i_rom),
    .d_req(d_req), .d_push(d_push), .d_tag(d_tag), .d_rom(d_rom),
    .q_done(q_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem), .q_tag(q_tag),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            i_d;
    bit            wr;
    bit            mem;
    logic [TW-1:0] tag;
    int            len;
    bit            to;
    int            gap;  // idle cycles before the grant, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_len = 0;     // cycle of the transfer in which q_done fires, 0 = never
  bit   mon_en = 1'b0;
  bit   both_gnt = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic bound_fail(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic push(bit i_d, bit wr, bit mem, logic [TW-1:0] tag, int len, bit to, int gap);
    exp_t e;
    e.i_d = i_d; e.wr = wr; e.mem = mem; e.tag = tag; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (q_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q_req) bound_fail("wait_idle");
    @(negedge clk);
  endtask

  task automatic wait_rises(int cnt, int bound);
    int  n = 0;
    int  seen = 0;
    bit  prev = q_req;
    while (seen < cnt && n < bound) begin
      @(negedge clk);
      n++;
      if (q_req && !prev) seen++;
      prev = q_req;
    end
    if (seen < cnt) bound_fail("wait_rises");
  endtask

  // qspi model: pulses q_done in cycle done_len of each transfer
  int rcnt = 0;
  initial begin
    q_done = 1'b0;
    forever begin
      @(negedge clk);
      if (q_req && !reset) begin
        rcnt++;
        q_done = (done_len != 0) && (rcnt == done_len);
      end else begin
        rcnt = 0;
        q_done = 1'b0;
      end
    end
  end

  // monitor
  bit   m_prev = 1'b0;
  bit   m_have = 1'b0;
  bit   m_frozen = 1'b1;
  int   m_len = 0;
  int   m_gap = 0;
  exp_t m_cur;
  initial begin
    forever begin
      @(negedge clk);
      if (i_gnt && d_gnt) both_gnt = 1'b1;
      if (!mon_en) begin
        m_prev = 1'b0; m_have = 1'b0; m_len = 0; m_gap = 0;
      end else begin
        if (q_req && !m_prev) begin
          if (exp_q.size() == 0) begin
            bound_fail("unexpected_grant");
            m_have = 1'b0;
          end else begin
            m_cur = exp_q.pop_front();
            m_have = 1'b1;
            check("cmd", {q_i_d, q_write, q_mem, q_tag}, {m_cur.i_d, m_cur.wr, m_cur.mem, m_cur.tag});
            check("gnt", {i_gnt, d_gnt, busy}, {m_cur.i_d, !m_cur.i_d, 1'b1});
            if (m_cur.gap >= 0) check("gap", m_gap, m_cur.gap);
          end
          m_len = 0;
          m_frozen = 1'b1;
          m_gap = 0;
        end
        if (q_req) begin
          m_len++;
          if (m_have && ({q_i_d, q_write, q_mem, q_tag, i_gnt, d_gnt} !==
                         {m_cur.i_d, m_cur.wr, m_cur.mem, m_cur.tag, m_cur.i_d, !m_cur.i_d}))
            m_frozen = 1'b0;
          if (timeout) m_frozen = 1'b0;
        end
        if (!q_req && m_prev && m_have) begin
          check("frozen", m_frozen, 1'b1);
          check("len", m_len, m_cur.len);
          check("timeout", timeout, m_cur.to);
          m_have = 1'b0;
        end
        if (!q_req) m_gap++;
        m_prev = q_req;
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_req = 0; i_tag = '0; i_rom = 0;
    d_req = 0; d_push = 0; d_tag = '0; d_rom = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset mid XFER_D, then D wins first after release
    @(negedge clk);
    check("rst_idle", {q_req, i_gnt, d_gnt, timeout}, 4'b0000);
    d_req = 1; d_tag = 20'h2AAAA; done_len = 0;
    @(negedge clk);
    check("rst_pre_gnt", {q_req, d_gnt}, 2'b11);
    check("rst_pre_tag", q_tag, 20'h2AAAA);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", {q_req, d_gnt, i_gnt, busy, q_i_d, q_write, q_mem}, 7'b0);
    check("rst_async_tag", q_tag, 20'h0);
    @(negedge clk);
    i_req = 1; i_tag = 20'h00001;
    reset = 1'b0;
    @(negedge clk);
    check("rst_first_d", {d_gnt, i_gnt}, 2'b10);
    reset = 1'b1;
    i_req = 0; d_req = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // single icache fill with input churn during the transfer
    done_len = 9;
    @(negedge clk);
    i_req = 1; i_tag = 20'h01234; i_rom = 1;
    push(1, 0, 1, 20'h01234, 9, 0, -1);
    @(negedge clk);
    check("lat_q_req", {q_req, i_gnt}, 2'b11);
    i_req = 0; i_tag = 20'h00F0F; i_rom = 0;
    wait_idle(50);

    // contention: D, I, D, I with one idle cycle between
    done_len = 8;
    i_req = 1; i_tag = 20'h01234; i_rom = 1;
    d_req = 1; d_push = 0; d_tag = 20'h00ABC; d_rom = 1;
    push(0, 0, 1, 20'h00ABC, 8, 0, -1);
    push(1, 0, 1, 20'h01234, 8, 0, 1);
    push(0, 0, 1, 20'h00ABC, 8, 0, 1);
    push(1, 0, 1, 20'h01234, 8, 0, 1);
    wait_rises(4, 200);
    i_req = 0; d_req = 0;
    wait_idle(50);

    // writeback lock: WB, then refill ahead of a waiting icache
    done_len = 6;
    d_req = 1; d_push = 1; d_tag = 20'h11111; d_rom = 1;
    push(0, 1, 0, 20'h11111, 6, 0, -1);
    push(0, 0, 1, 20'h33333, 6, 0, 1);
    push(1, 0, 0, 20'h22222, 6, 0, 1);
    wait_rises(1, 20);
    i_req = 1; i_tag = 20'h22222; i_rom = 0;
    d_push = 0; d_tag = 20'h33333;
    wait_rises(1, 20);
    d_req = 0;
    wait_rises(1, 20);
    i_req = 0;
    wait_idle(50);

    // watchdog abort, then q_done on the terminal cycle
    done_len = 0;
    d_req = 1; d_push = 0; d_tag = 20'h05555; d_rom = 0;
    push(0, 0, 0, 20'h05555, TIMEOUT, 1, -1);
    wait_rises(1, 20);
    d_req = 0;
    wait_idle(TIMEOUT + 20);
    check("post_to_clear", timeout, 1'b0);
    done_len = TIMEOUT;
    i_req = 1; i_tag = 20'h0AAAA; i_rom = 0;
    push(1, 0, 0, 20'h0AAAA, TIMEOUT, 0, -1);
    wait_rises(1, 20);
    i_req = 0;
    wait_idle(TIMEOUT + 20);

    // q_done while idle must not start anything
    q_done = 1'b1;
    @(negedge clk);
    check("idle_done_ign", {q_req, timeout}, 2'b00);
    repeat (3) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    check("gnt_exclusive", both_gnt, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/qspi_arb.md
# qspi_arb

Arbiter and sequencer for the single QSPI line-transfer engine shared by the instruction cache (line fills) and the data cache (dirty-line writebacks and line fills). It sits between the two caches' miss outputs and the `qspi` request port. It replaces the top-level combinational tag/request steering with registered, stable command outputs. It applies fair round-robin between caches, keeps a dcache writeback+refill pair atomic, and aborts a hung transfer with a watchdog.

## Interface
Parameters:
- `PA`, 22, physical address width
- `LINE_LENGTH`, 4, cache line length in bytes; `TW = PA - $clog2(LINE_LENGTH)` is the tag width
- `TIMEOUT`, 255, maximum cycles a granted transfer may stay open; counter width `CW = $clog2(TIMEOUT+1)`

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_req`  in  1  icache needs a line fill (ifetch & i_pull)
- `i_tag`  in  TW  icache line tag
- `i_rom`  in  1  icache fill targets ROM space
- `d_req`  in  1  dcache needs a line op ((rstrobe|wmask) & (d_pull|d_push) & !io_access)
- `d_push`  in  1  dcache op is a writeback; 0 = fill
- `d_tag`  in  TW  dcache line tag (victim tag while d_push=1)
- `d_rom`  in  1  dcache op targets ROM space
- `q_done`  in  1  one-cycle pulse from qspi on the final nibble of the line transfer
- `q_req`  out  1  transfer request to qspi, held for the whole transfer
- `q_i_d`  out  1  1 = icache transfer (steers qspi wstrobe_i vs wstrobe_d)
- `q_write`  out  1  1 = writeback
- `q_mem`  out  1  ROM/flash select (forced 0 when q_write=1)
- `q_tag`  out  TW  line tag for the transfer
- `i_gnt`  out  1  icache owns the engine
- `d_gnt`  out  1  dcache owns the engine
- `busy`  out  1  a transfer is open (= q_req)
- `timeout`  out  1  one-cycle pulse: watchdog aborted the open transfer

## Operation
- States: IDLE, XFER_I, XFER_D.
- IDLE:
  - `q_req=0`; evaluate requests every cycle.
  - Winner selection:
    - `lock` set and `d_req` → D.
    - Else only one requester → that one.
    - Else both → I if `last_d=1`, otherwise D.
  - On a winner, next edge:
    - Enter XFER_x.
    - Capture `q_tag`, `q_write` (= d_push for D, 0 for I), `q_mem` (= x_rom & !q_write), `q_i_d`.
    - Set the grant and clear the watchdog.
    - `last_d` ← (winner==D).
- XFER_x:
  - `q_req=1`; command outputs frozen regardless of input changes.
  - A requester dropping its request mid-transfer is ignored; the transfer always completes or times out.
  - Watchdog increments each cycle.
- `q_done` in XFER: next edge → IDLE, all grants and `q_req` to 0.
  - `lock` ← (state==XFER_D & q_write), so the refill following a writeback is granted before any icache request.
  - `lock` clears on any grant.
- Watchdog reaches TIMEOUT-1 without `q_done`: next edge → IDLE, `timeout=1` for that one cycle, `lock` ← 0.
- `q_done` and the watchdog terminal count in the same cycle: `q_done` wins, no timeout.
- `q_done` in IDLE is ignored.
- `i_gnt` and `d_gnt` are never both 1.

## Timing
- Registered outputs; no combinational path from inputs to outputs.
- Request seen in IDLE at cycle N → `q_req`, grant, and command valid at N+1.
- `q_done` at cycle M → `q_req=0` at M+1 (IDLE); next grant no earlier than M+2. The minimum 1-cycle gap guarantees qspi CS deassert between lines.
- Watchdog: with no `q_done`, `q_req` is high for exactly TIMEOUT cycles.
- Reset assertion (any time, including mid-transfer) immediately drives all outputs to 0 and sets state=IDLE, `last_d=0`, `lock=0`, watchdog=0.
- First arbitration after reset release favours D.

## Test plan
- Reset mid-XFER_D: assert reset async → `q_req`, `d_gnt`, `q_tag` are 0 before the next clk edge; after release with both requesting, D is granted first.
- Single icache fill: `i_req=1`, `i_tag=0x1234`, `i_rom=1` at cycle 0 → cycle 1 `q_req=1`, `q_i_d=1`, `q_mem=1`, `q_tag=0x1234`. `q_done` at cycle 9 → `q_req=0` at cycle 10.
- Contention: `i_req` and `d_req` held high continuously, `q_done` after 8 cycles each → grants alternate D, I, D, I with one idle cycle between each.
- Writeback lock: D push granted (`q_write=1`, `q_mem=0` even with `d_rom=1`); `i_req` high throughout; after `q_done`, dcache switches to `d_push=0` → D is granted again before I, then I.
- Input churn: change `i_tag` and drop `i_req` during XFER_I → `q_tag` and `q_req` unchanged until `q_done`.
- Watchdog: TIMEOUT=255, no `q_done` → `q_req` high 255 cycles, `timeout` pulses 1 cycle, return to IDLE. Repeat with `q_done` on the terminal cycle → no timeout pulse.
